// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop synchronizer, oversampled start/data/stop
// sampling, and a holding register with valid/ack, framing-error and overrun.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 uart_rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_s;
  logic                 good;

  assign rx_s      = sync_q[1];
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], uart_rx};
    prev_d  = prev_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    good    = 1'b0;

    if (rx_clk) begin
      prev_d = rx_s;
      case (state_q)
        // Requiring prev_q=1 keeps a held-low break from re-triggering.
        IDLE: if (prev_q && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
        START: if (tick_q == TICK_MID) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
        DATA: if (tick_q == TICK_LAST) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          tick_d  = '0;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        STOP: if (tick_q == TICK_LAST) begin
          state_d = IDLE;
          tick_d  = '0;
          if (rx_s) good = 1'b1;
          else      ferr_d = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    if (rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    // A byte completing alongside an ack wins; the ack only suppresses overrun.
    if (good) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 16 ticks/bit, rx_clk every 4th sys_clk,
// so a frame is 640 cycles and the stop-bit sample lands on cycle 612.
module tb_uart_receiver;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b0, rx_clk = 1'b0, uart_rx = 1'b1, rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int errors = 0, checks = 0;
  int fe_cnt = 0, fe_wide = 0, rise_at = -1;
  logic fe_prev = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_clk(rx_clk), .uart_rx(uart_rx),
    .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge sys_clk) begin
    if (frame_err) fe_cnt++;
    if (frame_err && fe_prev) fe_wide++;
    fe_prev = frame_err;
  end

  // Drives one 10-bit frame; ack_at/ncyc let a test ack or cut the frame at an exact cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at, input int ncyc);
    logic [9:0] fr;
    logic vprev;
    fr = {stop, d, 1'b0};
    vprev = rx_valid;
    rise_at = -1;
    for (int g = 0; g < ncyc; g++) begin
      @(negedge sys_clk);
      if (!vprev && rx_valid && rise_at < 0) rise_at = g;
      vprev = rx_valid;
      uart_rx = fr[g/64];
      rx_clk  = (g % 4 == 3);
      rx_ack  = (g == ack_at);
    end
    @(negedge sys_clk);
    rx_clk = 1'b0;
    rx_ack = 1'b0;
  endtask

  task automatic line_level(input logic lvl, input int ticks);
    for (int g = 0; g < ticks * 4; g++) begin
      @(negedge sys_clk);
      uart_rx = lvl;
      rx_clk  = (g % 4 == 3);
    end
    @(negedge sys_clk);
    rx_clk = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge sys_clk) rx_ack = 1'b1;
    @(negedge sys_clk) rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk) rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    rst = 1'b0;
    line_level(1'b1, 32);
  endtask

  task automatic test_basic();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, -1, 640);
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %b want 0", overrun); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_ferr: got %0d pulses want 0", fe_cnt - fe0); end
    checks++; if (rise_at != 612) begin errors++; $display("FAIL basic_latency: got cycle %0d want 612", rise_at); end
    do_ack();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b want 0", rx_valid); end
    do_ack();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL idle_ack_data: got %h want a5", rx_data); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    line_level(1'b1, 16);
    line_level(1'b0, 4);
    line_level(1'b1, 32);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", fe_cnt - fe0); end
    send_frame(8'h3C, 1'b1, -1, 640);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data: got %h want 3c", rx_data); end
    checks++; if (rise_at != 612) begin errors++; $display("FAIL glitch_next_latency: got cycle %0d want 612", rise_at); end
    do_ack();
  endtask

  task automatic test_frame_err();
    int fe0;
    send_frame(8'h66, 1'b1, -1, 640);
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, 640);
    line_level(1'b1, 16);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_count: got %0d pulses want 1", fe_cnt - fe0); end
    checks++; if (fe_wide != 0) begin errors++; $display("FAIL ferr_width: got %0d wide pulses want 0", fe_wide); end
    checks++; if (rx_data !== 8'h66) begin errors++; $display("FAIL ferr_data: got %h want 66", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ferr_valid: got %b want 1", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ferr_ovr: got %b want 0", overrun); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, -1, 640);
    send_frame(8'h22, 1'b1, -1, 640);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h want 22", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_ovr: got %b want 1", overrun); end
    do_ack();
    checks++; if ({rx_valid, overrun} !== 2'b00) begin errors++; $display("FAIL b2b_ack: got %b want 00", {rx_valid, overrun}); end
    send_frame(8'h11, 1'b1, -1, 640);
    send_frame(8'h22, 1'b1, 611, 640);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL race_data: got %h want 22", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL race_valid: got %b want 1", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL race_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h11, 1'b1, -1, 640);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL pre_rst_ovr: got %b want 1", overrun); end
    send_frame(8'hFF, 1'b1, -1, 276);
    rst = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", rx_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr: got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_ferr: got %b want 0", frame_err); end
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    line_level(1'b1, 128);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_spurious: got %b want 0", rx_valid); end
    send_frame(8'h00, 1'b1, -1, 640);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_next_data: got %h want 00", rx_data); end
    checks++; if (rise_at != 612) begin errors++; $display("FAIL rst_next_latency: got cycle %0d want 612", rise_at); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_next_ovr: got %b want 0", overrun); end
    do_ack();
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    line_level(1'b0, 30 * 16);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL break_ferr: got %0d pulses want 1", fe_cnt - fe0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_valid: got %b want 0", rx_valid); end
    line_level(1'b1, 32);
    send_frame(8'h5A, 1'b1, -1, 640);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL break_next_data: got %h want 5a", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL break_next_valid: got %b want 1", rx_valid); end
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL break_ferr_after: got %0d pulses want 1", fe_cnt - fe0); end
    checks++; if (fe_wide != 0) begin errors++; $display("FAIL break_ferr_width: got %0d wide pulses want 0", fe_wide); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_break();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
